// File: rtl/shift_mult_ctrl_if.sv
// Operand/result handshake and shifter-control bundle for shift_mult_ctrl.
// The controller connects through the slave modport; the operand source / shifter side uses master.
interface shift_mult_ctrl_if #(
    parameter int WIDTH   = 4,
    parameter int SHIFT_W = 2
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic [WIDTH-1:0]     sh_in;
    logic [SHIFT_W-1:0]   sh_shift;
    logic [2*WIDTH-1:0]   sh_out;
    logic [2*WIDTH-1:0]   product;
    logic                 valid;
    logic                 ack;

    modport slave (
        input  start, a, b, sh_out, ack,
        output ready, busy, sh_in, sh_shift, product, valid
    );

    modport master (
        output start, a, b, sh_out, ack,
        input  ready, busy, sh_in, sh_shift, product, valid
    );
endinterface

// File: rtl/shift_mult_ctrl.sv
// Shift-and-add multiplier controller driving an external combinational left-shifter.
// Optional MULT_EARLY_EXIT_EN: finish as soon as no higher multiplier bits remain set.
module shift_mult_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SHIFT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    shift_mult_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SHIFT_W-1:0] IDX_LAST = SHIFT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [SHIFT_W-1:0]   idx_q, idx_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 last_bit;

`ifdef MULT_EARLY_EXIT_EN
    // One extra bit so idx+1 cannot wrap when WIDTH is a power of two.
    logic [SHIFT_W:0]     idx_nx;
    assign idx_nx   = {1'b0, idx_q} + (SHIFT_W+1)'(1);
    assign last_bit = (idx_q == IDX_LAST) || ((b_q >> idx_nx) == '0);
`else
    assign last_bit = (idx_q == IDX_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        prod_d  = prod_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    prod_d  = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (b_q[idx_q]) begin
                    prod_d = prod_q + bus.sh_out;
                end
                if (last_bit) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + SHIFT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready    = (state_q == S_IDLE);
        bus.busy     = (state_q == S_BUSY);
        bus.valid    = (state_q == S_DONE);
        bus.sh_in    = (state_q == S_BUSY) ? a_q : '0;
        bus.sh_shift = (state_q == S_BUSY) ? idx_q : '0;
        bus.product  = prod_q;
    end
endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Self-checking bench for shift_mult_ctrl: directed cases plus randomized operations against a cycle-level model.
module tb_shift_mult_ctrl;
    localparam int WIDTH   = 4;
    localparam int SHIFT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    bit cmp_en = 1'b0;

    shift_mult_ctrl_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) bus ();

    shift_mult_ctrl #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External combinational left-shifter.
    assign bus.sh_out = {{WIDTH{1'b0}}, bus.sh_in} << bus.sh_shift;

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned lat_of(input int unsigned bv);
`ifdef MULT_EARLY_EXIT_EN
        return (bv == 0) ? 1 : $clog2(bv + 1);
`else
        return WIDTH;
`endif
    endfunction

    // Behavioural model: phase 0 idle, 1 multiplying, 2 result held.
    int unsigned m_ph = 0, m_a = 0, m_b = 0, m_cnt = 0, m_lat = 0, m_prod = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph <= 0; m_a <= 0; m_b <= 0; m_cnt <= 0; m_prod <= 0;
        end else begin
            case (m_ph)
                0: if (bus.start) begin
                    m_a <= bus.a; m_b <= bus.b; m_cnt <= 0;
                    m_lat <= lat_of(bus.b); m_prod <= 0; m_ph <= 1;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == m_lat) begin
                        m_ph <= 2;
                        m_prod <= m_a * m_b;
                    end
                end
                default: if (bus.ack) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int unsigned exp_prod;
            exp_prod = (m_ph == 1) ? m_a * (m_b % (32'd1 << m_cnt)) : m_prod;
            chk("m_ready", bus.ready, m_ph == 0);
            chk("m_busy",  bus.busy,  m_ph == 1);
            chk("m_valid", bus.valid, m_ph == 2);
            chk("m_product", bus.product, exp_prod);
            chk("m_sh_in", bus.sh_in, (m_ph == 1) ? m_a : 0);
            chk("m_sh_shift", bus.sh_shift, (m_ph == 1) ? m_cnt : 0);
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic run_op(input int unsigned av, input int unsigned bv,
                          input int unsigned exp_prod, input int exp_lat, input int hold);
        int n;
        bus.a = av[WIDTH-1:0];
        bus.b = bv[WIDTH-1:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(n);
        chk("latency", n, exp_lat);
        chk("product", bus.product, exp_prod);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", bus.valid, 1);
            chk("hold_product", bus.product, exp_prod);
        end
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("ready_after_ack", bus.ready, 1);
        chk("valid_after_ack", bus.valid, 0);
    endtask

    initial begin
        int n;
        int guard;
        bus.start = 1'b0; bus.ack = 1'b0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_ready", bus.ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_valid", bus.valid, 0);
        chk("reset_product", bus.product, 0);

`ifdef MULT_EARLY_EXIT_EN
        run_op(3, 5, 15, 3, 0);
        run_op(15, 15, 225, 4, 10);
        run_op(0, 9, 0, 4, 0);
        run_op(9, 0, 0, 1, 0);
        run_op(7, 2, 14, 2, 0);
`else
        run_op(3, 5, 15, 4, 0);
        run_op(15, 15, 225, 4, 10);
        run_op(0, 9, 0, 4, 0);
        run_op(9, 0, 0, 4, 0);
        run_op(7, 2, 14, 4, 0);
`endif
        chk("idle_holds_product", bus.product, 14);

        // Reset during the second multiply cycle.
        bus.a = 4'd6; bus.b = 4'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", bus.ready, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_product", bus.product, 0);
`ifdef MULT_EARLY_EXIT_EN
        run_op(2, 2, 4, 2, 0);
`else
        run_op(2, 2, 4, 4, 0);
`endif

        // start held high with changing operands; only the first accept counts.
        bus.a = 4'd5; bus.b = 4'd3; bus.start = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.valid && n < 20) begin
            bus.a = 4'($urandom); bus.b = 4'($urandom);
            @(negedge clk);
            n++;
        end
        chk("ign_product", bus.product, 15);
        repeat (2) @(negedge clk);
        chk("ign_done_valid", bus.valid, 1);
        chk("ign_done_product", bus.product, 15);
        bus.a = 4'd1; bus.b = 4'd1; bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("ign_ack_only", bus.ready, 1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_accept", bus.busy, 1);
        wait_valid(n);
        chk("b2b_first", bus.product, 1);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        run_op(15, 1, 15, int'(lat_of(1)), 0);

        // Randomized operations with start/ack noise.
        for (int unsigned it = 0; it < 60; it++) begin
            guard = 0;
            while (!bus.ready && guard < 40) begin
                bus.ack = bus.valid;
                @(negedge clk);
                guard++;
            end
            bus.ack = 1'b0;
            if (!bus.ready) chk("rand_drain_timeout", 0, 1);
            bus.a = 4'($urandom); bus.b = 4'($urandom); bus.start = 1'b1;
            @(negedge clk);
            guard = 0;
            while (!bus.valid && guard < 20) begin
                bus.start = 1'($urandom);
                bus.ack = 1'($urandom);
                bus.a = 4'($urandom); bus.b = 4'($urandom);
                @(negedge clk);
                guard++;
            end
            bus.ack = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                bus.start = 1'($urandom);
                @(negedge clk);
            end
            bus.start = 1'($urandom);
            bus.ack = 1'b1;
            @(negedge clk);
            bus.ack = 1'b0;
            bus.start = 1'b0;
        end
        repeat (12) begin
            bus.ack = bus.valid;
            @(negedge clk);
        end
        bus.ack = 1'b0;

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_mult_ctrl.md
Name: shift_mult_ctrl

Overview:
- Sequential shift-and-add multiplier controller that sequences the team's external combinational left-shifter.
- Accepts two unsigned operands and, for each set multiplier bit, drives the shifter with the multiplicand and the bit index.
- Accumulates the shifter output into a double-width product and returns it over a valid/ack handshake.
- Sits between the operand source and the shifter datapath; the shifter itself stays a separate module.

Parameters:
- WIDTH, 4, operand width in bits; product and shifter output are 2*WIDTH.
- SHIFT_W, 2, shift-amount width; must equal ceil(log2(WIDTH)).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operand request; accepted only when ready=1.
- a  input  WIDTH  multiplicand, sampled on accept.
- b  input  WIDTH  multiplier, sampled on accept.
- ready  output  1  high only in IDLE.
- busy  output  1  high only in BUSY.
- sh_in  output  WIDTH  to shifter data input: a_reg in BUSY, else 0.
- sh_shift  output  SHIFT_W  to shifter shift input: idx in BUSY, else 0.
- sh_out  input  2*WIDTH  shifter result, combinational from sh_in and sh_shift.
- product  output  2*WIDTH  accumulator register.
- valid  output  1  product valid; high only in DONE.
- ack  input  1  consumer accepts product.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (wins over all inputs, including mid-operation):
  - state = IDLE; a_reg = b_reg = 0; idx = 0; product = 0.
  - ready = 1; busy = 0; valid = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at an edge latches a_reg = a, b_reg = b; clears product to 0; sets idx = 0; next state is BUSY.
  - start=0 keeps IDLE, and product holds its last value.
- BUSY, one multiplier bit per edge:
  - If b_reg[idx]=1, product <= product + sh_out; otherwise product holds.
  - If idx == WIDTH-1, next state is DONE; otherwise idx <= idx+1.
- DONE:
  - valid=1, and product is stable.
  - ack=1 at an edge moves to IDLE. valid stays high until then; no timeout.
- Latency (feature off): start accepted at edge E0; bits 0..WIDTH-1 processed at E1..E(WIDTH); valid=1 after E(WIDTH). Default is 4 cycles. Fixed, data-independent.
- Throughput:
  - The earliest next accept is the edge after ack, because ready is low in DONE.
  - Minimum period is WIDTH+2 cycles.
- Arithmetic:
  - Unsigned throughout.
  - The accumulator is 2*WIDTH bits and cannot overflow, since (2^W-1)^2 < 2^(2W).
  - sh_out is added at full width with no truncation.
- Boundary conditions:
  - start in BUSY or DONE is ignored, and the operands are not re-sampled.
  - ack in IDLE or BUSY is ignored.
  - start and ack high together in DONE: only ack takes effect; start must be re-presented in IDLE.
  - a or b changing after accept has no effect.
  - a=0 or b=0: the full WIDTH cycles run (feature off), giving product 0.
  - idx never exceeds WIDTH-1 and never wraps.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: in BUSY, if idx == WIDTH-1 or (b_reg >> (idx+1)) == 0, the next state is DONE after processing the current bit.
  - Latency is 1 + (index of the highest set bit of b); b=0 gives 1 cycle.
  - Product value is identical to the feature-off result.
- Undefined: fixed WIDTH-cycle latency as above; no extra logic.

Test Plan:
- Basic multiply: reset, then a=3, b=5, start pulse -> valid high exactly 4 cycles after accept, product=15; sh_shift steps 0,1,2,3 during BUSY; ack returns to IDLE with ready=1.
- Maximum operands: a=15, b=15 -> product=225 with no overflow; hold ack=0 for 10 cycles -> valid and product stay at 225; ack=1 -> IDLE next cycle.
- Zero operands: a=0, b=9 -> product=0. a=9, b=0 -> product=0 with 4-cycle latency; with MULT_EARLY_EXIT_EN, 1-cycle latency. a=7, b=2 with the macro -> product=14 in 2 cycles.
- Reset mid-operation: accept a=6, b=7; assert rst during the second BUSY cycle -> next cycle IDLE, product=0, valid=0, ready=1. A new op a=2, b=2 then gives product=4.
- Ignored requests: start held high through BUSY and DONE with changing a/b -> result reflects only the first accepted operands. Next accept occurs only in IDLE after ack. Back-to-back ops 1x1 then 15x1 -> products 1, then 15.
